// File: rtl/data_memory_pkg.sv
// Shared types and the power-on fill pattern for param_data_memory.
package data_memory_pkg;

    typedef enum logic {
        INIT,
        IDLE
    } dm_state_t;

    localparam int unsigned INIT_MAX_W = 256;

    // Lower half counts up from 0, upper half counts down from 0 (two's complement).
    function automatic logic [INIT_MAX_W-1:0] init_pattern(
        input int unsigned index,
        input int unsigned depth,
        input int unsigned data_w
    );
        logic [INIT_MAX_W-1:0] value;
        logic [INIT_MAX_W-1:0] mask;
        if (index < depth / 2)
            value = INIT_MAX_W'(index);
        else
            value = INIT_MAX_W'(0) - INIT_MAX_W'(index - depth / 2);
        if (data_w >= INIT_MAX_W)
            mask = '1;
        else
            mask = (INIT_MAX_W'(1) << data_w) - INIT_MAX_W'(1);
        return value & mask;
    endfunction

endpackage

// File: rtl/dm_init_seq.sv
// Initialisation word counter; done marks the final fill write.
module dm_init_seq #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             restart,
    output logic [IDX_W-1:0] idx,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    always_comb begin
        done = active && !restart && (idx == LAST_IDX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            idx <= '0;
        else if (restart)
            idx <= '0;
        else if (active)
            idx <= done ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/param_data_memory.sv
// Single-port word memory with self-initialisation and 1-cycle read latency.
// Define PARAM_DATA_MEMORY_BE_EN to add the req_be byte-enable port.
module param_data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init_req,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
`ifdef PARAM_DATA_MEMORY_BE_EN
    input  logic [DATA_W/8-1:0] req_be,
`endif
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                addr_err,
    output logic                init_busy
);

    localparam int unsigned     IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    dm_state_t         state;
    dm_state_t         state_next;
    logic [IDX_W-1:0]  init_idx;
    logic              init_done;
    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  addr_idx;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] mem [DEPTH];

    dm_init_seq #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_init_seq (
        .clk     (clk),
        .reset   (reset),
        .active  (state == INIT),
        .restart (init_req),
        .idx     (init_idx),
        .done    (init_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (init_done) state_next = IDLE;
            IDLE:    if (init_req)  state_next = INIT;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        init_busy = (state == INIT);
        req_ready = (state == IDLE) && !init_req;
    end

    assign accept   = req_valid && req_ready;
    assign in_range = {1'b0, req_addr} < DEPTH_LIM;
    assign addr_idx = req_addr[IDX_W-1:0];

`ifdef PARAM_DATA_MEMORY_BE_EN
    always_comb begin
        wr_mask = '0;
        for (int unsigned b = 0; b < DATA_W / 8; b++)
            wr_mask[b*8 +: 8] = {8{req_be[b]}};
    end
`else
    assign wr_mask = '1;
`endif

    // Held in reset, state is INIT at index 0, so edges during reset only rewrite word 0
    // with its own fill value, which INIT rewrites again after release.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[init_idx] <= DATA_W'(init_pattern(32'(init_idx), DEPTH, DATA_W));
        else if (accept && req_write && in_range)
            mem[addr_idx] <= (mem[addr_idx] & ~wr_mask) | (req_wdata & wr_mask);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            addr_err  <= 1'b0;
        end else begin
            rsp_valid <= accept && !req_write;
            addr_err  <= accept && !in_range;
            if (accept && !req_write)
                rsp_rdata <= in_range ? mem[addr_idx] : '0;
        end
    end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits; must be a multiple of 8 and at least 8.
REQ-002 SHALL have parameter DEPTH, default 32: number of words; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter ADDR_W, default 8: request address width; must be at least clog2(DEPTH).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port init_req, input, 1: synchronous request to re-run initialisation.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: request accepted this cycle when req_valid is also 1.
REQ-009 SHALL have port req_write, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, ADDR_W: word address.
REQ-011 SHALL have port req_wdata, input, DATA_W: write data.
REQ-012 SHALL have port req_be, input, DATA_W/8: byte enables; present only when the byte-enable macro (REQ-030) is defined.
REQ-013 SHALL have port rsp_valid, output, 1: read data valid.
REQ-014 SHALL have port rsp_rdata, output, DATA_W: read data.
REQ-015 SHALL have port addr_err, output, 1: the accepted request addressed a word at or beyond DEPTH.
REQ-016 SHALL have port init_busy, output, 1: initialisation in progress.

Function
REQ-017 SHALL implement two states: INIT and IDLE.
REQ-018 INIT: SHALL write one word per cycle at index i = 0..DEPTH-1; value = i for i < DEPTH/2, else (-(i-DEPTH/2)) mod 2^DATA_W; exactly DEPTH cycles, then go to IDLE.
REQ-019 SHALL drive init_busy=1 and req_ready=0 throughout INIT.
REQ-020 req_ready SHALL be 1 exactly when state==IDLE and init_req==0 (combinational).
REQ-021 Accepted read: rsp_valid=1 and rsp_rdata=mem[addr] on the next cycle (latency 1); otherwise rsp_valid=0 and rsp_rdata holds its last value.
REQ-022 Accepted write: mem[addr] SHALL be updated at the accepting edge; no response; a read of the same address accepted on the next cycle SHALL return the new data.
REQ-023 Back-to-back accepted requests SHALL be supported every cycle; throughput is 1 request per cycle.
REQ-024 Address >= DEPTH: a write SHALL be ignored; a read SHALL return 0 with rsp_valid=1; addr_err SHALL pulse 1 for one cycle on the cycle after acceptance (reads and writes).
REQ-025 init_req=1 in IDLE: SHALL enter INIT on the next edge, and any simultaneous request SHALL not be accepted; init_req during INIT SHALL restart the index at 0.
REQ-026 Read data SHALL reflect memory contents before any write at the same edge; only one request can be accepted per cycle, so no such conflict can arise.

Reset
REQ-027 reset low SHALL immediately force: state=INIT, init index=0, rsp_valid=0, rsp_rdata=0, addr_err=0, init_busy=1.
REQ-028 A reset asserted mid-INIT or mid-request SHALL abort it; the memory array is not cleared asynchronously, and initialisation restarts after reset release.
REQ-029 The first INIT write SHALL occur on the first rising clk edge with reset high.

Configuration
REQ-030 With macro PARAM_DATA_MEMORY_BE_EN defined: a write SHALL update only the bytes whose req_be bit is 1; req_be=0 SHALL be a legal no-op write that still reports addr_err.
REQ-031 Without PARAM_DATA_MEMORY_BE_EN: port req_be SHALL be absent and every write SHALL update the full word.

Structure
REQ-032 Package data_memory_pkg SHALL hold the state enum (INIT, IDLE) and the init-pattern function (index, DEPTH, DATA_W -> value).
REQ-033 Sub-module dm_init_seq SHALL contain the INIT index counter and the done flag; the array, request path and response path stay in param_data_memory.

Verification
REQ-034 Default parameters, release reset: init_busy high for exactly 32 cycles; then read addr 5 -> 0x05, addr 16 -> 0x00, addr 17 -> 0xFF, addr 31 -> 0xF1.
REQ-035 Write 0xA5 to addr 3, read addr 3 on the next cycle -> rsp_valid one cycle later with rsp_rdata=0xA5; 4 back-to-back reads on consecutive cycles -> 4 consecutive rsp_valid cycles.
REQ-036 Read addr 40 -> rsp_rdata=0x00 and addr_err=1 for one cycle; write 0x77 to addr 40 -> addr_err pulse, and a read of addr 8 still returns 0x08.
REQ-037 Assert init_req alongside req_valid with a write to addr 2 -> req_ready=0, write dropped; after 32 cycles a read of addr 2 -> 0x02.
REQ-038 Pull reset low at INIT cycle 10 -> rsp_valid=0 and init_busy=1 immediately; after release -> full 32-cycle INIT, then reads match REQ-034.
REQ-039 DATA_W=32 with PARAM_DATA_MEMORY_BE_EN: write 0xDEADBEEF with be=4'b0101 to addr 1 -> reading addr 1 returns 0x00AD00EF.
